exmem_pipe: RTL and testbench
=============================

# exmem_pipe

Parametrised EX/MEM pipeline register for the 5-stage core. It carries the ALU result, destination register and a widened control bundle from execute to memory through `STAGES` back-to-back register slots. Each slot has a valid bit, and the chain uses a valid/ready handshake for stalls, a synchronous flush for squashing wrong-path instructions, and per-slot hazard taps for the forwarding unit. It also keeps an occupancy count and a bubble counter for performance tracking.

## Interface
- `DATA_W`, 32, width of the ALU result.
- `CTRL_W`, 8, control bundle width. Must be ≥ 5.
  - bit 0: RegWrite
  - bit 1: MemRead
  - bit 2: MemtoReg
  - bit 3: MemWrite
  - bits [CTRL_W-1:4]: ALUControl, carried at full width.
- `STAGES`, 1, number of register slots, 1..4.
- `OCC_W`, $clog2(STAGES+1), occupancy width.

Ports:
- `clk`  in  1  single clock; every register updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  squashes every slot and blocks input for that cycle.
- `in_valid`  in  1  execute stage presents an instruction.
- `in_ready`  out  1  slot 0 can accept this cycle (combinational).
- `in_aluresult`  in  DATA_W  ALU result.
- `in_rd`  in  5  destination register.
- `in_ctrl`  in  CTRL_W  control bundle.
- `out_valid`  out  1  valid bit of the last slot.
- `out_ready`  in  1  memory stage accepts.
- `out_aluresult`, `out_rd`, `out_ctrl`  out  DATA_W / 5 / CTRL_W  contents of the last slot.
- `hz_rd`  out  5*STAGES  rd of slot k at bits [5k+4:5k].
- `hz_regwrite`  out  STAGES  bit k = valid[k] & ctrl[k][0].
- `occupancy`  out  OCC_W  number of valid slots.
- `bubble_cnt`  out  16  saturating count of cycles with out_ready=1 and out_valid=0.

## Operation
- Slot 0 is on the input side; slot STAGES-1 drives the outputs.
- Slot k holds `v[k]`, aluresult, rd and ctrl.
- Ready chain, combinational:
  - `rdy[STAGES-1] = !v[STAGES-1] | out_ready`
  - `rdy[k] = !v[k] | rdy[k+1]`
  - `in_ready = rdy[0] & !flush`
- Per cycle, when `rst=0` and `flush=0`:
  - Slot k>0 with `rdy[k]`: loads slot k-1 (valid and payload).
  - Slot 0 with `rdy[0]`: loads the input and sets `v[0]=in_valid`.
  - A slot whose `rdy` is 0 holds its contents.
- Bubble rule: every slot that ends up invalid has its ctrl forced to 0. A squashed or empty slot can therefore never assert RegWrite or MemWrite downstream. aluresult and rd of invalid slots are don't-care but deterministic (they load as normal).
- Flush, when `rst=0` and `flush=1`:
  - Next cycle: every `v[k]=0` and every ctrl=0.
  - The input is not accepted (`in_ready=0`).
  - An output handshake (`out_valid & out_ready`) in the flush cycle still completes; the consumer owns that instruction.
- occupancy = popcount(v). It is registered alongside v and must equal popcount(v) every cycle.
- bubble_cnt increments by 1 when out_ready=1 and out_valid=0, and holds at 16'hFFFF once it saturates. It is not cleared by flush.

## Timing
- Reset (`rst=1` at an edge): all v, aluresult, rd, ctrl, occupancy and bubble_cnt become 0. Outputs read 0 from the next cycle. `rst` has priority over flush and the handshake.
- Latency: with out_ready held 1, a transfer accepted at edge t shows out_valid=1 after edge t+STAGES-1. For STAGES=1 it is visible in the cycle after acceptance, matching the legacy register.
- Throughput is one instruction per cycle with out_ready=1. Only a full chain with out_ready=0 drives in_ready=0.
- Back-pressure: with out_ready=0, valid entries compress toward the output. After STAGES accepted inputs, in_ready=0. Payload in a held slot must not change.
- Simultaneous events:
  - Input accept in the same cycle as an output pop on a full chain is legal; occupancy stays unchanged.
  - flush together with in_valid=1: the input is dropped.
  - rst together with flush: reset wins.
- in_ready, hz_* and out_* have no combinational path from in_* data. in_ready depends only on v, out_ready and flush.

## Test plan
- Reset: `rst=1` for 2 cycles with in_valid=1 and in_ctrl=8'hFF. Required: out_valid=0, out_ctrl=0, occupancy=0, bubble_cnt=0 throughout and after.
- Streaming, STAGES=2, out_ready=1: feed aluresult=100,101,102 with rd=1,2,3 on consecutive cycles. Required: each appears on out_* exactly 2 edges after acceptance, in order, with no gaps.
- Back-pressure, STAGES=3, out_ready=0: feed 5 inputs. Required:
  - in_ready drops after the 3rd accept; occupancy=3.
  - Raising out_ready then drains 100,101,102 in order, and inputs 4 and 5 follow.
- Flush: fill STAGES=3 with ctrl=8'h09 (RegWrite+MemWrite), then pulse flush with in_valid=1. Required:
  - Next cycle: occupancy=0, hz_regwrite=3'b000, out_ctrl=0.
  - The flushed-cycle input never appears.
- Hazard taps, STAGES=2: inject rd=7 (RegWrite=1), then rd=9 (RegWrite=0). Required: hz_rd={5'd7,5'd9} and hz_regwrite=2'b10 in the cycle both are resident.
- Bubble counter: hold out_ready=1 and in_valid=0 for 70000 cycles. Required: bubble_cnt saturates at 16'hFFFF and stays there.

Source files
------------

// File: rtl/exmem_pipe.sv
// EX/MEM pipeline register: STAGES back-to-back slots with valid/ready stalls,
// synchronous flush, per-slot forwarding taps, occupancy and bubble counters.
module exmem_pipe #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int STAGES = 1,
    parameter int OCC_W  = $clog2(STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_aluresult,
    input  logic [4:0]            in_rd,
    input  logic [CTRL_W-1:0]     in_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_aluresult,
    output logic [4:0]            out_rd,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [5*STAGES-1:0]   hz_rd,
    output logic [STAGES-1:0]     hz_regwrite,
    output logic [OCC_W-1:0]      occupancy,
    output logic [15:0]           bubble_cnt
);

    logic [STAGES-1:0] v_q, v_d;
    logic [DATA_W-1:0] alu_q  [STAGES];
    logic [DATA_W-1:0] alu_d  [STAGES];
    logic [4:0]        rd_q   [STAGES];
    logic [4:0]        rd_d   [STAGES];
    logic [CTRL_W-1:0] ctrl_q [STAGES];
    logic [CTRL_W-1:0] ctrl_d [STAGES];
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [15:0]       bubble_q, bubble_d;
    logic [STAGES-1:0] rdy;

    // A slot can take new data if it is empty or everything downstream of it moves.
    always_comb begin
        logic r;
        rdy = '0;
        r = !v_q[STAGES-1] | out_ready;
        rdy[STAGES-1] = r;
        for (int k = STAGES - 2; k >= 0; k--) begin
            r = !v_q[k] | r;
            rdy[k] = r;
        end
    end

    assign in_ready = rdy[0] & !flush;

    always_comb begin
        v_d    = v_q;
        alu_d  = alu_q;
        rd_d   = rd_q;
        ctrl_d = ctrl_q;
        if (flush) begin
            v_d = '0;
            for (int k = 0; k < STAGES; k++) begin
                ctrl_d[k] = '0;
            end
        end else begin
            if (rdy[0]) begin
                v_d[0]    = in_valid;
                alu_d[0]  = in_aluresult;
                rd_d[0]   = in_rd;
                ctrl_d[0] = in_valid ? in_ctrl : '0;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v_d[k]    = v_q[k-1];
                    alu_d[k]  = alu_q[k-1];
                    rd_d[k]   = rd_q[k-1];
                    // Bubbles carry zero control so they can never write downstream.
                    ctrl_d[k] = v_q[k-1] ? ctrl_q[k-1] : '0;
                end
            end
        end

        occ_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ_d = occ_d + OCC_W'(v_d[k]);
        end

        bubble_d = bubble_q;
        if (out_ready && !v_q[STAGES-1] && (bubble_q != 16'hFFFF)) begin
            bubble_d = bubble_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q      <= '0;
            occ_q    <= '0;
            bubble_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                alu_q[k]  <= '0;
                rd_q[k]   <= '0;
                ctrl_q[k] <= '0;
            end
        end else begin
            v_q      <= v_d;
            occ_q    <= occ_d;
            bubble_q <= bubble_d;
            alu_q    <= alu_d;
            rd_q     <= rd_d;
            ctrl_q   <= ctrl_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_hz
            assign hz_rd[5*gi +: 5] = rd_q[gi];
            assign hz_regwrite[gi]  = v_q[gi] & ctrl_q[gi][0];
        end
    endgenerate

    assign out_valid     = v_q[STAGES-1];
    assign out_aluresult = alu_q[STAGES-1];
    assign out_rd        = rd_q[STAGES-1];
    assign out_ctrl      = ctrl_q[STAGES-1];
    assign occupancy     = occ_q;
    assign bubble_cnt    = bubble_q;

endmodule

// File: tb/tb_exmem_pipe.sv
// Directed bench for exmem_pipe: a 2-slot and a 3-slot instance share clk/rst.
module tb_exmem_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 2-slot instance
    logic        flush2, in_valid2, in_ready2, out_valid2, out_ready2;
    logic [31:0] in_alu2, out_alu2;
    logic [4:0]  in_rd2, out_rd2;
    logic [7:0]  in_ctrl2, out_ctrl2;
    logic [9:0]  hz_rd2;
    logic [1:0]  hz_rw2;
    logic [1:0]  occ2;
    logic [15:0] bub2;

    // 3-slot instance
    logic        flush3, in_valid3, in_ready3, out_valid3, out_ready3;
    logic [31:0] in_alu3, out_alu3;
    logic [4:0]  in_rd3, out_rd3;
    logic [7:0]  in_ctrl3, out_ctrl3;
    logic [14:0] hz_rd3;
    logic [2:0]  hz_rw3;
    logic [1:0]  occ3;
    logic [15:0] bub3;

    int checks = 0;
    int passes = 0;

    exmem_pipe #(.DATA_W(32), .CTRL_W(8), .STAGES(2)) d2 (
        .clk(clk), .rst(rst), .flush(flush2),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_aluresult(in_alu2), .in_rd(in_rd2), .in_ctrl(in_ctrl2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_aluresult(out_alu2), .out_rd(out_rd2), .out_ctrl(out_ctrl2),
        .hz_rd(hz_rd2), .hz_regwrite(hz_rw2),
        .occupancy(occ2), .bubble_cnt(bub2)
    );

    exmem_pipe #(.DATA_W(32), .CTRL_W(8), .STAGES(3)) d3 (
        .clk(clk), .rst(rst), .flush(flush3),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .in_aluresult(in_alu3), .in_rd(in_rd3), .in_ctrl(in_ctrl3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_aluresult(out_alu3), .out_rd(out_rd3), .out_ctrl(out_ctrl3),
        .hz_rd(hz_rd3), .hz_regwrite(hz_rw3),
        .occupancy(occ3), .bubble_cnt(bub3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush2 = 1'b0; flush3 = 1'b0;
        in_valid2 = 1'b1; in_alu2 = 32'd55; in_rd2 = 5'd4; in_ctrl2 = 8'hFF; out_ready2 = 1'b1;
        in_valid3 = 1'b1; in_alu3 = 32'd66; in_rd3 = 5'd5; in_ctrl3 = 8'hFF; out_ready3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                rst = 1'b0; in_valid2 = 1'b0; in_valid3 = 1'b0;
                out_ready2 = 1'b0; out_ready3 = 1'b0;
            end
            tick();
            checks++;
            if (out_valid2 !== 1'b0) $display("FAIL reset_out_valid2 cyc %0d got %b want 0", i, out_valid2);
            else passes++;
            checks++;
            if (out_ctrl2 !== 8'h00) $display("FAIL reset_out_ctrl2 cyc %0d got %h want 00", i, out_ctrl2);
            else passes++;
            checks++;
            if (occ2 !== 2'd0) $display("FAIL reset_occ2 cyc %0d got %0d want 0", i, occ2);
            else passes++;
            checks++;
            if (bub2 !== 16'd0) $display("FAIL reset_bubble2 cyc %0d got %0d want 0", i, bub2);
            else passes++;
            checks++;
            if (out_valid3 !== 1'b0 || occ3 !== 2'd0 || out_ctrl3 !== 8'h00)
                $display("FAIL reset_d3 cyc %0d got v=%b occ=%0d ctrl=%h want 0/0/00", i, out_valid3, occ3, out_ctrl3);
            else passes++;
        end
        $display("reset done");
    endtask

    task automatic test_streaming();
        out_ready2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid2 = (i < 3);
            in_alu2   = 32'd100 + 32'(i);
            in_rd2    = 5'(i + 1);
            in_ctrl2  = 8'h05;
            @(negedge clk);
            checks++;
            if (in_ready2 !== 1'b1) $display("FAIL stream_in_ready step %0d got %b want 1", i, in_ready2);
            else passes++;
            tick();
            if (i >= 1 && i <= 3) begin
                checks++;
                if (out_valid2 !== 1'b1 || out_alu2 !== 32'd99 + 32'(i) || out_rd2 !== 5'(i) || out_ctrl2 !== 8'h05)
                    $display("FAIL stream_out step %0d got v=%b alu=%0d rd=%0d ctrl=%h want 1/%0d/%0d/05",
                             i, out_valid2, out_alu2, out_rd2, out_ctrl2, 99 + i, i);
                else begin
                    passes++;
                    $display("stream out alu=%0d rd=%0d", out_alu2, out_rd2);
                end
            end else begin
                checks++;
                if (out_valid2 !== 1'b0 || out_ctrl2 !== 8'h00)
                    $display("FAIL stream_bubble step %0d got v=%b ctrl=%h want 0/00", i, out_valid2, out_ctrl2);
                else passes++;
            end
        end
        in_valid2 = 1'b0;
    endtask

    task automatic test_backpressure();
        int send;
        int recv;
        logic acc;
        out_ready3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid3 = 1'b1; in_alu3 = 32'd100 + 32'(i); in_rd3 = 5'(i + 1); in_ctrl3 = 8'h01;
            @(negedge clk);
            checks++;
            if (in_ready3 !== 1'b1) $display("FAIL bp_in_ready_fill %0d got %b want 1", i, in_ready3);
            else passes++;
            tick();
            checks++;
            if (occ3 !== 2'(i + 1)) $display("FAIL bp_occ_fill %0d got %0d want %0d", i, occ3, i + 1);
            else passes++;
        end
        in_alu3 = 32'd103; in_rd3 = 5'd4;
        @(negedge clk);
        checks++;
        if (in_ready3 !== 1'b0) $display("FAIL bp_in_ready_full got %b want 0", in_ready3);
        else passes++;
        tick();
        checks++;
        if (occ3 !== 2'd3 || out_valid3 !== 1'b1 || out_alu3 !== 32'd100)
            $display("FAIL bp_hold got occ=%0d v=%b alu=%0d want 3/1/100", occ3, out_valid3, out_alu3);
        else passes++;
        checks++;
        if (hz_rd3 !== {5'd1, 5'd2, 5'd3} || hz_rw3 !== 3'b111)
            $display("FAIL bp_hz got rd=%h rw=%b want %h/111", hz_rd3, hz_rw3, {5'd1, 5'd2, 5'd3});
        else passes++;

        // Full chain, pop and push in the same cycle.
        out_ready3 = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready3 !== 1'b1 || out_alu3 !== 32'd100)
            $display("FAIL bp_first_drain got rdy=%b alu=%0d want 1/100", in_ready3, out_alu3);
        else begin
            passes++;
            $display("drain out alu=%0d", out_alu3);
        end
        tick();
        checks++;
        if (occ3 !== 2'd3 || out_alu3 !== 32'd101)
            $display("FAIL bp_push_pop got occ=%0d alu=%0d want 3/101", occ3, out_alu3);
        else passes++;
        send = 4;
        recv = 1;
        for (int c = 0; c < 20 && recv < 5; c++) begin
            in_valid3 = (send < 5);
            in_alu3   = 32'd100 + 32'(send);
            in_rd3    = 5'(send + 1);
            @(negedge clk);
            acc = in_valid3 & in_ready3;
            if (out_valid3 & out_ready3) begin
                checks++;
                if (out_alu3 !== 32'd100 + 32'(recv) || out_rd3 !== 5'(recv + 1))
                    $display("FAIL bp_drain_order %0d got alu=%0d rd=%0d want %0d/%0d",
                             recv, out_alu3, out_rd3, 100 + recv, recv + 1);
                else begin
                    passes++;
                    $display("drain out alu=%0d", out_alu3);
                end
                recv++;
            end
            tick();
            if (acc) send++;
        end
        in_valid3 = 1'b0;
        checks++;
        if (recv !== 5) $display("FAIL bp_drain_count got %0d want 5", recv);
        else passes++;
        tick();
        checks++;
        if (occ3 !== 2'd0) $display("FAIL bp_empty_occ got %0d want 0", occ3);
        else passes++;
    endtask

    task automatic test_flush();
        out_ready3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid3 = 1'b1; in_alu3 = 32'd200 + 32'(i); in_rd3 = 5'(10 + i); in_ctrl3 = 8'h09;
            tick();
        end
        checks++;
        if (occ3 !== 2'd3 || hz_rw3 !== 3'b111 || out_ctrl3 !== 8'h09)
            $display("FAIL flush_fill got occ=%0d rw=%b ctrl=%h want 3/111/09", occ3, hz_rw3, out_ctrl3);
        else passes++;
        flush3 = 1'b1; in_alu3 = 32'd999; in_rd3 = 5'd31;
        @(negedge clk);
        checks++;
        if (in_ready3 !== 1'b0) $display("FAIL flush_in_ready got %b want 0", in_ready3);
        else passes++;
        tick();
        flush3 = 1'b0; in_valid3 = 1'b0;
        checks++;
        if (occ3 !== 2'd0 || hz_rw3 !== 3'b000 || out_ctrl3 !== 8'h00 || out_valid3 !== 1'b0)
            $display("FAIL flush_clear got occ=%0d rw=%b ctrl=%h v=%b want 0/000/00/0",
                     occ3, hz_rw3, out_ctrl3, out_valid3);
        else passes++;
        out_ready3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid3 !== 1'b0)
                $display("FAIL flush_leak cyc %0d got v=%b alu=%0d want v=0", i, out_valid3, out_alu3);
            else passes++;
        end
    endtask

    task automatic test_hazard();
        out_ready2 = 1'b0;
        in_valid2 = 1'b1; in_alu2 = 32'd7; in_rd2 = 5'd7; in_ctrl2 = 8'h01;
        tick();
        in_rd2 = 5'd9; in_alu2 = 32'd9; in_ctrl2 = 8'h00;
        tick();
        in_valid2 = 1'b0;
        checks++;
        if (hz_rd2 !== {5'd7, 5'd9}) $display("FAIL hz_rd got %h want %h", hz_rd2, {5'd7, 5'd9});
        else passes++;
        checks++;
        if (hz_rw2 !== 2'b10) $display("FAIL hz_regwrite got %b want 10", hz_rw2);
        else passes++;
        @(negedge clk);
        checks++;
        if (in_ready2 !== 1'b0 || occ2 !== 2'd2)
            $display("FAIL hz_full got rdy=%b occ=%0d want 0/2", in_ready2, occ2);
        else passes++;
    endtask

    task automatic test_bubble();
        rst = 1'b1;
        tick();
        rst = 1'b0; out_ready2 = 1'b1; in_valid2 = 1'b0;
        checks++;
        if (bub2 !== 16'd0) $display("FAIL bubble_start got %0d want 0", bub2);
        else passes++;
        repeat (100) tick();
        checks++;
        if (bub2 !== 16'd100) $display("FAIL bubble_100 got %0d want 100", bub2);
        else passes++;
        repeat (65434) tick();
        checks++;
        if (bub2 !== 16'hFFFE) $display("FAIL bubble_fffe got %h want fffe", bub2);
        else passes++;
        tick();
        checks++;
        if (bub2 !== 16'hFFFF) $display("FAIL bubble_sat got %h want ffff", bub2);
        else passes++;
        repeat (1000) tick();
        checks++;
        if (bub2 !== 16'hFFFF) $display("FAIL bubble_hold got %h want ffff", bub2);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_hazard();
        test_bubble();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1, "timeout");
    end

endmodule
